// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: RV32I opcodes, instruction classes and immediate formats.
package decode_stage_pkg;

    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpMiscMem = 7'b0001111;
    localparam logic [6:0] OpImm     = 7'b0010011;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpReg     = 7'b0110011;
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpSystem  = 7'b1110011;

    typedef enum logic [3:0] {
        OcNop, OcAluR, OcAluI, OcLoad, OcStore, OcBranch,
        OcJal, OcJalr, OcLui, OcAuipc, OcSystem, OcIllegal
    } opclass_e;

    typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

    // Everything execute needs from one decoded instruction; all-zero is the reset/NOP value.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        opclass_e    opclass;
        logic [2:0]  funct3;
        logic        funct7b5;
    } ex_bundle_t;

    function automatic logic uses_rs1(opclass_e c);
        return !(c inside {OcLui, OcAuipc, OcJal, OcIllegal});
    endfunction

    function automatic logic uses_rs2(opclass_e c);
        return c inside {OcAluR, OcStore, OcBranch};
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate extraction; every format is sign-extended from instruction bit 31.
module imm_gen
    import decode_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] imm_o
);

    logic unused_bits;
    assign unused_bits = ^{instr_i[14:12], instr_i[6:0]};

    always_comb begin
        imm_o = '0;
        case (fmt_i)
            ImmI: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            ImmS: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            ImmB: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                           instr_i[11:8], 1'b0};
            ImmU: imm_o = {instr_i[31:12], 12'h000};
            ImmJ: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry holding register towards execute with load-use bubble and flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_instr_i,
    input  logic [31:0] if_pc_i,
    output logic        id_ready_o,
    output logic [4:0]  ar1_o,
    output logic [4:0]  ar2_o,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_imm_o,
    output logic [4:0]  ex_rd_o,
    output logic [4:0]  ex_rs1_o,
    output logic [4:0]  ex_rs2_o,
    output opclass_e    ex_opclass_o,
    output logic [2:0]  ex_funct3_o,
    output logic        ex_funct7b5_o
);

    logic       ex_valid_q, ex_valid_d;
    ex_bundle_t ex_q, ex_d;

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [4:0]  in_rs1, in_rs2;
    opclass_e    dec_class;
    imm_fmt_e    dec_fmt;
    logic [31:0] dec_imm;
    logic        hazard;
    logic        accept;

    assign opcode = if_instr_i[6:0];
    assign funct7 = if_instr_i[31:25];
    assign in_rs1 = if_instr_i[19:15];
    assign in_rs2 = if_instr_i[24:20];

    always_comb begin
        dec_class = OcIllegal;
        dec_fmt   = ImmNone;
        case (opcode)
            OpLui:     begin dec_class = OcLui;    dec_fmt = ImmU; end
            OpAuipc:   begin dec_class = OcAuipc;  dec_fmt = ImmU; end
            OpJal:     begin dec_class = OcJal;    dec_fmt = ImmJ; end
            OpJalr:    begin dec_class = OcJalr;   dec_fmt = ImmI; end
            OpBranch:  begin dec_class = OcBranch; dec_fmt = ImmB; end
            OpLoad:    begin dec_class = OcLoad;   dec_fmt = ImmI; end
            OpStore:   begin dec_class = OcStore;  dec_fmt = ImmS; end
            OpImm:     begin dec_class = OcAluI;   dec_fmt = ImmI; end
            OpReg: begin
                if (funct7 == 7'h00 || funct7 == 7'h20) dec_class = OcAluR;
            end
            OpSystem:  dec_class = OcSystem;
            // FENCE has no effect in this single-issue pipe; pass it on as a NOP.
            OpMiscMem: dec_class = OcNop;
            default:   dec_class = OcIllegal;
        endcase
    end

    imm_gen u_imm_gen (
        .instr_i (if_instr_i),
        .fmt_i   (dec_fmt),
        .imm_o   (dec_imm)
    );

    always_comb begin
        hazard = 1'b0;
        if (LOAD_USE_STALL && if_valid_i && ex_valid_q && ex_q.opclass == OcLoad &&
            ex_q.rd != 5'd0) begin
            hazard = (uses_rs1(dec_class) && in_rs1 == ex_q.rd) ||
                     (uses_rs2(dec_class) && in_rs2 == ex_q.rd);
        end
    end

    assign id_ready_o = rst_ni && (flush_i || ((!ex_valid_q || ex_ready_i) && !hazard));
    assign accept     = if_valid_i && id_ready_o && !flush_i;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d  = 1'b1;
            ex_d.pc       = if_pc_i;
            ex_d.imm      = dec_imm;
            ex_d.rd       = if_instr_i[11:7];
            ex_d.rs1      = in_rs1;
            ex_d.rs2      = in_rs2;
            ex_d.opclass  = dec_class;
            ex_d.funct3   = if_instr_i[14:12];
            ex_d.funct7b5 = if_instr_i[30];
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    // Register file is read on the same edge that loads ex_*, so data stays aligned when stalled.
    assign ar1_o = (if_valid_i && id_ready_o) ? in_rs1 : ex_q.rs1;
    assign ar2_o = (if_valid_i && id_ready_o) ? in_rs2 : ex_q.rs2;

    assign ex_valid_o    = ex_valid_q;
    assign ex_pc_o       = ex_q.pc;
    assign ex_imm_o      = ex_q.imm;
    assign ex_rd_o       = ex_q.rd;
    assign ex_rs1_o      = ex_q.rs1;
    assign ex_rs2_o      = ex_q.rs2;
    assign ex_opclass_o  = ex_q.opclass;
    assign ex_funct3_o   = ex_q.funct3;
    assign ex_funct7b5_o = ex_q.funct7b5;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: assembler-style random stimulus plus directed corner cases.
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        opclass_e    cls;
        logic [31:0] imm;
        logic        u1;
        logic        u2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush, if_valid, ex_ready;
    logic [31:0] if_instr, if_pc;

    logic        id_ready, ex_valid, ex_funct7b5;
    logic [4:0]  ar1, ar2, ex_rd, ex_rs1, ex_rs2;
    logic [31:0] ex_pc, ex_imm;
    logic [2:0]  ex_funct3;
    opclass_e    ex_opclass;

    logic        n_id_ready, n_ex_valid, n_ex_funct7b5;
    logic [4:0]  n_ar1, n_ar2, n_ex_rd, n_ex_rs1, n_ex_rs2;
    logic [31:0] n_ex_pc, n_ex_imm;
    logic [2:0]  n_ex_funct3;
    opclass_e    n_ex_opclass;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    logic        m_valid, m_load;
    logic [4:0]  m_rd;
    logic [31:0] m_instr;

    always #5 clk = ~clk;

    decode_stage #(.LOAD_USE_STALL(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .if_valid_i(if_valid),
        .if_instr_i(if_instr), .if_pc_i(if_pc), .id_ready_o(id_ready), .ar1_o(ar1),
        .ar2_o(ar2), .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_pc_o(ex_pc),
        .ex_imm_o(ex_imm), .ex_rd_o(ex_rd), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2),
        .ex_opclass_o(ex_opclass), .ex_funct3_o(ex_funct3), .ex_funct7b5_o(ex_funct7b5)
    );

    decode_stage #(.LOAD_USE_STALL(1'b0)) dut_nostall (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .if_valid_i(if_valid),
        .if_instr_i(if_instr), .if_pc_i(if_pc), .id_ready_o(n_id_ready), .ar1_o(n_ar1),
        .ar2_o(n_ar2), .ex_valid_o(n_ex_valid), .ex_ready_i(ex_ready), .ex_pc_o(n_ex_pc),
        .ex_imm_o(n_ex_imm), .ex_rd_o(n_ex_rd), .ex_rs1_o(n_ex_rs1), .ex_rs2_o(n_ex_rs2),
        .ex_opclass_o(n_ex_opclass), .ex_funct3_o(n_ex_funct3),
        .ex_funct7b5_o(n_ex_funct7b5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input opclass_e c,
                                input logic [31:0] imm);
        exp_t e;
        e.instr = instr;
        e.pc    = $urandom;
        e.cls   = c;
        e.imm   = imm;
        case (c)
            OcLui, OcAuipc, OcJal, OcIllegal: e.u1 = 1'b0;
            default:                          e.u1 = 1'b1;
        endcase
        case (c)
            OcAluR, OcStore, OcBranch: e.u2 = 1'b1;
            default:                   e.u2 = 1'b0;
        endcase
        return e;
    endfunction

    // Assemble a random instruction from chosen fields; the chosen fields are the expectation.
    function automatic exp_t gen();
        int          k   = $urandom_range(0, 12);
        logic [4:0]  rd  = 5'($urandom_range(0, 7));
        logic [4:0]  rs1 = 5'($urandom_range(0, 7));
        logic [4:0]  rs2 = 5'($urandom_range(0, 7));
        logic [2:0]  f3  = 3'($urandom);
        logic [31:0] o;
        logic [6:0]  op;
        logic [6:0]  f7;
        case (k)
            0: begin
                f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
                return mk({f7, rs2, rs1, f3, rd, 7'b0110011}, OcAluR, 32'h0);
            end
            1: begin
                o = 32'($urandom_range(0, 4095)) - 32'd2048;
                return mk({o[11:0], rs1, f3, rd, 7'b0010011}, OcAluI, o);
            end
            2: begin
                o = 32'($urandom_range(0, 4095)) - 32'd2048;
                return mk({o[11:0], rs1, f3, rd, 7'b0000011}, OcLoad, o);
            end
            3: begin
                o = 32'($urandom_range(0, 4095)) - 32'd2048;
                return mk({o[11:0], rs1, 3'b000, rd, 7'b1100111}, OcJalr, o);
            end
            4: begin
                o = 32'($urandom_range(0, 4095)) - 32'd2048;
                return mk({o[11:5], rs2, rs1, f3, o[4:0], 7'b0100011}, OcStore, o);
            end
            5: begin
                o = 32'd2 * 32'($urandom_range(0, 4095)) - 32'd4096;
                return mk({o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'b1100011},
                          OcBranch, o);
            end
            6: begin
                o = 32'd2 * 32'($urandom_range(0, 1048575)) - 32'd1048576;
                return mk({o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111}, OcJal, o);
            end
            7: begin
                o = {20'($urandom), 12'h000};
                return mk({o[31:12], rd, 7'b0110111}, OcLui, o);
            end
            8: begin
                o = {20'($urandom), 12'h000};
                return mk({o[31:12], rd, 7'b0010111}, OcAuipc, o);
            end
            9:  return mk({25'($urandom), 7'b1110011}, OcSystem, 32'h0);
            10: begin
                do op = 7'($urandom);
                while (op inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63,
                                  7'h67, 7'h6F, 7'h73});
                return mk({25'($urandom), op}, OcIllegal, 32'h0);
            end
            11: begin
                do f7 = 7'($urandom); while (f7 == 7'h00 || f7 == 7'h20);
                return mk({f7, rs2, rs1, f3, rd, 7'b0110011}, OcIllegal, 32'h0);
            end
            default: return mk({25'($urandom), 7'b0001111}, OcNop, 32'h0);
        endcase
    endfunction

    // One cycle: drive, check handshake against the model, then advance the model past the edge.
    task automatic step(input logic v, input exp_t e, input logic rdy, input logic fl);
        logic hz, exp_rdy;
        if_valid = v;
        if_instr = e.instr;
        if_pc    = e.pc;
        ex_ready = rdy;
        flush    = fl;
        hz = v && m_valid && m_load && (m_rd != 5'd0) &&
             ((e.u1 && e.instr[19:15] == m_rd) || (e.u2 && e.instr[24:20] == m_rd));
        exp_rdy = fl || ((!m_valid || rdy) && !hz);
        #1;
        chk("id_ready", 32'(id_ready), 32'(exp_rdy));
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ar1", 32'(ar1), 32'((v && exp_rdy) ? e.instr[19:15] : m_instr[19:15]));
        chk("ar2", 32'(ar2), 32'((v && exp_rdy) ? e.instr[24:20] : m_instr[24:20]));
        @(posedge clk);
        #1;
        if (fl) begin
            m_valid = 1'b0;
        end else if (v && exp_rdy) begin
            m_valid = 1'b1;
            m_load  = (e.cls == OcLoad);
            m_rd    = e.instr[11:7];
            m_instr = e.instr;
            sb.push_back(e);
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input exp_t e);
        rst_n    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = e.instr;
        if_pc    = e.pc;
        m_valid  = 1'b0;
        m_load   = 1'b0;
        m_rd     = 5'd0;
        m_instr  = 32'h0;
        sb.delete();
        #1;
        chk("reset ex_valid", 32'(ex_valid), 32'h0);
        chk("reset id_ready", 32'(id_ready), 32'h0);
        chk("reset opclass", 32'(ex_opclass), 32'(OcNop));
        chk("reset ex_pc", ex_pc, 32'h0);
        chk("reset ex_imm", ex_imm, 32'h0);
        chk("reset ex_rd", 32'(ex_rd), 32'h0);
        @(posedge clk);
        #1;
        chk("reset hold ex_valid", 32'(ex_valid), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: whatever execute sees must match the oldest expected instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ex_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious ex_valid: got opclass %0d pc 0x%h, expected none",
                             ex_opclass, ex_pc);
                end else begin
                    e = sb[0];
                    chk("ex_opclass", 32'(ex_opclass), 32'(e.cls));
                    chk("ex_pc", ex_pc, e.pc);
                    chk("ex_imm", ex_imm, e.imm);
                    chk("ex_rd", 32'(ex_rd), 32'(e.instr[11:7]));
                    chk("ex_rs1", 32'(ex_rs1), 32'(e.instr[19:15]));
                    chk("ex_rs2", 32'(ex_rs2), 32'(e.instr[24:20]));
                    chk("ex_funct3", 32'(ex_funct3), 32'(e.instr[14:12]));
                    chk("ex_funct7b5", 32'(ex_funct7b5), 32'(e.instr[30]));
                    if (ex_ready || flush) sb.delete(0);
                end
            end
        end
    end

    initial begin
        exp_t addi, lw, add, lui, idle, ea, eb;
        addi = mk(32'hFFF08293, OcAluI, 32'hFFFFFFFF);
        lw   = mk(32'h00012183, OcLoad, 32'h0);
        add  = mk(32'h00118233, OcAluR, 32'h0);
        lui  = mk(32'h123453B7, OcLui, 32'h12345000);
        idle = mk(32'h00000013, OcAluI, 32'h0);

        #2;
        do_reset(addi);
        step(1'b1, addi, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        // Load-use: one bubble in the stalling decoder, none in the other.
        do_reset(lw);
        step(1'b1, lw, 1'b1, 1'b0);
        step(1'b1, add, 1'b1, 1'b0);
        chk("nostall ex_valid", 32'(n_ex_valid), 32'h1);
        chk("nostall opclass", 32'(n_ex_opclass), 32'(OcAluR));
        step(1'b1, add, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        // Backpressure on LUI for three cycles.
        step(1'b1, lui, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, addi, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        // Flush with a held instruction and a simultaneous offer.
        ea = gen();
        eb = mk(32'h00500093, OcAluI, 32'h5);
        step(1'b1, ea, 1'b0, 1'b0);
        step(1'b1, eb, 1'b0, 1'b1);
        step(1'b0, idle, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        step(1'b1, mk(32'hFFFFFFFF, OcIllegal, 32'h0), 1'b1, 1'b0);
        step(1'b1, mk(32'h02118233, OcIllegal, 32'h0), 1'b1, 1'b0);
        step(1'b1, mk(32'hFE000EE3, OcBranch, 32'hFFFFFFFC), 1'b1, 1'b0);
        step(1'b1, mk(32'h0010006F, OcJal, 32'h00000800), 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, gen(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b1, 1'b0);
        chk("scoreboard drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
